// File: rtl/instr_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_ctrl_if
//  Brief    : Memory read port and decode-side valid/ready bundle of the
//             instruction fetch sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] instruction_address;
    logic [DATA_W-1:0] instruction_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output instruction_address,
        input  instruction_data,
        output instr_valid,
        input  instr_ready,
        output instr_out,
        output instr_pc
    );

    modport slave (
        input  instruction_address,
        output instruction_data,
        input  instr_valid,
        output instr_ready,
        input  instr_out,
        input  instr_pc
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_ctrl
//  Brief    : PC sequencer for a combinational instruction memory feeding a
//             small prefetch FIFO; handles start, redirect, halt opcode and
//             end-of-program. Define INSTR_FETCH_WRAP_EN to loop the program.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter int                PROG_DEPTH  = 6,
    parameter int                FIFO_DEPTH  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(8'hFF)
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic              redirect_valid,
    input  wire logic [ADDR_W-1:0] redirect_addr,
    instr_fetch_ctrl_if.master     bus,
    output logic                   busy,
    output logic                   halted,
    output logic                   pc_err
);

    localparam int                  c_ptr_w      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                  c_cnt_w      = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]  c_fifo_full  = c_cnt_w'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0]   c_last_pc    = ADDR_W'(PROG_DEPTH - 1);
    localparam logic [ADDR_W:0]     c_prog_depth = (ADDR_W + 1)'(PROG_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_next;
    logic                r_pc_err;
    logic                w_pc_err_next;

    logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]   r_fifo_pc   [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    logic                w_active;
    logic                w_redirect_ok;
    logic                w_push;
    logic                w_pop;
    logic                w_flush;

    assign w_active      = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign w_redirect_ok = ({1'b0, redirect_addr} < c_prog_depth);
    assign w_pop         = (r_count != '0) && bus.instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_pc_err <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_pc_err <= w_pc_err_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_pc_err_next = 1'b0;
        w_push        = 1'b0;
        w_flush       = 1'b0;

        // A redirect outranks fetch, pop and start while the sequencer is active.
        if (w_active && redirect_valid) begin
            w_flush = 1'b1;
            if (w_redirect_ok) begin
                w_pc_next    = redirect_addr;
                w_state_next = S_FETCH;
            end else begin
                w_pc_err_next = 1'b1;
                w_state_next  = S_HALTED;
            end
        end else begin
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        w_state_next = S_FETCH;
                        w_pc_next    = RESET_PC;
                    end
                end
                S_FETCH: begin
                    // A full FIFO still accepts a fetch when its head leaves this cycle.
                    if ((r_count != c_fifo_full) || w_pop) begin
                        w_push = 1'b1;
                        if (bus.instruction_data == HALT_OPCODE) begin
                            w_state_next = S_DRAIN;
                        end else if (r_pc == c_last_pc) begin
`ifdef INSTR_FETCH_WRAP_EN
                            w_pc_next = '0;
`else
                            w_state_next = S_DRAIN;
`endif
                        end else begin
                            w_pc_next = r_pc + ADDR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_count == '0) begin
                        w_state_next = S_HALTED;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= bus.instruction_data;
                r_fifo_pc[r_wr_ptr]   <= r_pc;
                r_wr_ptr              <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.instruction_address = r_pc;
    assign bus.instr_valid         = (r_count != '0);
    assign bus.instr_out           = r_fifo_data[r_rd_ptr];
    assign bus.instr_pc            = r_fifo_pc[r_rd_ptr];
    assign busy                    = w_active;
    assign halted                  = (r_state == S_HALTED);
    assign pc_err                  = r_pc_err;

endmodule
`default_nettype wire
